// File: rtl/hilo_commit_if.sv
// HI/LO write-back bus: MEM-stage request and stage controls in, WB latch and
// architectural HI/LO/write-count out.
interface hilo_commit_if #(
  parameter int CNT_W = 32
);
  logic             stall_mem;
  logic             stall_wb;
  logic             flush;
  logic [31:0]      mem_hi_i;
  logic [31:0]      mem_lo_i;
  logic             mem_whilo_i;
  logic [31:0]      wb_hi_o;
  logic [31:0]      wb_lo_o;
  logic             wb_whilo_o;
  logic [31:0]      hi_o;
  logic [31:0]      lo_o;
  logic [CNT_W-1:0] wr_cnt_o;

  modport master (
    output stall_mem, stall_wb, flush, mem_hi_i, mem_lo_i, mem_whilo_i,
    input  wb_hi_o, wb_lo_o, wb_whilo_o, hi_o, lo_o, wr_cnt_o
  );

  modport slave (
    input  stall_mem, stall_wb, flush, mem_hi_i, mem_lo_i, mem_whilo_i,
    output wb_hi_o, wb_lo_o, wb_whilo_o, hi_o, lo_o, wr_cnt_o
  );
endinterface

// File: rtl/hilo_commit.sv
// MEM/WB latch for HI/LO writes plus architectural HI/LO commit and write count.
// Optional write-through read port: define HILO_BYPASS_EN.
module hilo_commit #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  hilo_commit_if.slave bus
);
  typedef struct packed {
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_req_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hilo_req_t        mem_req;
  hilo_req_t        wb_q, wb_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;

  assign mem_req = '{whilo: bus.mem_whilo_i, hi: bus.mem_hi_i, lo: bus.mem_lo_i};

  // Flush outranks stall; a MEM stall with WB running inserts a bubble.
  always_comb begin
    wb_d = wb_q;
    if (bus.flush)
      wb_d = '0;
    else if (bus.stall_mem && !bus.stall_wb)
      wb_d = '0;
    else if (!bus.stall_mem)
      wb_d = mem_req;
  end

  // The latched entry commits even on a flush edge: it is past the exception point.
  assign commit = wb_q.whilo && !bus.stall_wb;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (commit) begin
      hi_d = wb_q.hi;
      lo_d = wb_q.lo;
      if (!(&cnt_q))
        cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= wb_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.wb_hi_o    = wb_q.hi;
  assign bus.wb_lo_o    = wb_q.lo;
  assign bus.wb_whilo_o = wb_q.whilo;
  assign bus.wr_cnt_o   = cnt_q;

`ifdef HILO_BYPASS_EN
  // Write-through: the pending WB value is visible on the read port immediately.
  assign bus.hi_o = wb_q.whilo ? wb_q.hi : hi_q;
  assign bus.lo_o = wb_q.whilo ? wb_q.lo : lo_q;
`else
  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;
`endif
endmodule

// File: doc/hilo_commit.md
# hilo_commit

Write-side end of the HI/LO path in the MIPS pipeline. Accepts HI/LO write requests leaving the memory-access stage and holds them in the MEM/WB pipeline latch, obeying pipeline stall and flush. Commits them into the architectural HI and LO registers one cycle later. Exposes the latched write-back request for EX-stage forwarding and the architectural values as the HI/LO read port.

## Interface
- CNT_W, 32, width of the committed-write counter
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high
- stall_mem  in  1  memory-access stage stalled
- stall_wb  in  1  write-back stage stalled
- flush  in  1  pipeline flush (exception/eret)
- mem_hi_i  in  32  HI value from memory-access stage
- mem_lo_i  in  32  LO value from memory-access stage
- mem_whilo_i  in  1  HI/LO write request from memory-access stage
- wb_hi_o  out  32  latched HI value in write-back stage (forwarding source)
- wb_lo_o  out  32  latched LO value in write-back stage (forwarding source)
- wb_whilo_o  out  1  latched write request in write-back stage
- hi_o  out  32  HI read port
- lo_o  out  32  LO read port
- wr_cnt_o  out  CNT_W  number of committed HI/LO writes, saturating

## Operation
- Two register groups:
  - WB latch: wb_hi_o, wb_lo_o, wb_whilo_o.
  - Architectural: HI, LO, wr_cnt_o.
- WB latch update, evaluated per edge in priority order:
  - rst: all zero.
  - flush: wb_whilo_o <= 0; wb_hi_o and wb_lo_o <= 0.
  - stall_mem=1 and stall_wb=0: bubble. wb_whilo_o <= 0, data <= 0.
  - stall_mem=1 and stall_wb=1: hold all latch fields.
  - stall_mem=0: latch mem_hi_i, mem_lo_i, mem_whilo_i.
  - stall_mem=0 with stall_wb=1 is illegal (ctrl never produces it). The latch loads anyway; this is not checked.
- Architectural commit:
  - Commit happens when wb_whilo_o=1, stall_wb=0 and rst=0.
  - On commit: HI <= wb_hi_o, LO <= wb_lo_o, wr_cnt_o <= wr_cnt_o+1.
  - The counter saturates at all-ones.
  - When wb_whilo_o=1 and stall_wb=1, nothing commits and the latch holds, so the write commits after the stall releases. It is counted exactly once.
  - flush does not cancel the commit of the entry already in the WB latch. That instruction is past the exception point. The commit and the latch clear occur on the same edge.
- HI and LO are always written together. A write from MTHI carries the unchanged LO, already merged upstream.
- hi_o/lo_o: see Configuration.

## Timing
- Reset (synchronous, one edge): wb_hi_o=0, wb_lo_o=0, wb_whilo_o=0, HI=0, LO=0, wr_cnt_o=0.
- rst mid-operation discards any pending latched write. No commit occurs on the reset edge.
- Latency, no stalls:
  - Request at MEM in cycle N appears on wb_*_o after edge N.
  - It reaches HI/LO after edge N+1.
  - Architectural visibility without bypass is 2 edges after the MEM-stage request.
- Back-to-back requests on consecutive cycles each commit in order; the later one wins.
- Every output is a register or a register mux; there is no combinational path from mem_*_i.

## Configuration
- HILO_BYPASS_EN defined:
  - hi_o = wb_whilo_o ? wb_hi_o : HI; lo_o likewise.
  - Write-through read port. The decode/EX consumer sees the WB value in the same cycle without the WB forwarding path.
  - Applies even while stall_wb=1.
- HILO_BYPASS_EN undefined: hi_o=HI and lo_o=LO, raw registers. EX forwarding must use wb_*_o.

## Test plan
- Reset: hold rst=1 with mem_whilo_i=1, mem_hi_i=0x1234 for 3 edges -> all outputs 0, wr_cnt_o=0.
- Basic commit: cycle 0 mem_whilo_i=1, hi=0xAAAA0001, lo=0x5555000F.
  - After edge 1: wb_whilo_o=1.
  - After edge 2: hi_o=0xAAAA0001, lo_o=0x5555000F, wr_cnt_o=1.
  - With HILO_BYPASS_EN: hi_o already equals 0xAAAA0001 after edge 1.
- Bubble: stall_mem=1, stall_wb=0 while mem_whilo_i=1 -> wb_whilo_o=0 next edge; HI/LO unchanged; wr_cnt_o unchanged.
- Hold: latched write present with stall_mem=stall_wb=1 for 4 cycles.
  - During the stall: HI unchanged, wb_whilo_o stays 1.
  - After release: commit once, wr_cnt_o increments by exactly 1.
- Flush: latched write 0x00000007/0x00000009 plus flush=1 and a new mem_whilo_i=1 request.
  - HI=7, LO=9 commit on that edge.
  - wb_whilo_o=0 afterwards; the new request is discarded.
- Back-to-back: requests 0x1, 0x2, 0x3 on consecutive cycles -> HI sequence 1, 2, 3 on successive edges; wr_cnt_o=3.
- Saturation: force wr_cnt_o near all-ones, issue 3 commits -> wr_cnt_o stays all-ones.
